// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - N-channel valid/ready mux with manual select and round-robin auto-scan
// Optional CHAN_MUX_PARITY_EN adds a registered even-parity bit (out_par) for the output word.
module chan_mux_scan #(
  parameter int N_CH = 4,
  parameter int DW   = 16,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH-1:0]    chan_en,
  output logic [DW-1:0]      out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
`ifdef CHAN_MUX_PARITY_EN
  output logic               out_par,
`endif
  input  logic               out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] cand;
  logic [DW-1:0]   cand_data;
  logic            ld;
  logic            chan_ok;
  logic            xfer;

  // First enabled channel strictly after p, wrapping; p itself if no other is enabled.
  function automatic logic [SELW-1:0] next_en(input logic [SELW-1:0] p,
                                               input logic [N_CH-1:0] en);
    logic [SELW-1:0] r;
    logic [SELW-1:0] ix;
    logic            found;
    r     = p;
    found = 1'b0;
    for (int i = 1; i < N_CH; i++) begin
      ix = SELW'((int'(p) + i) % N_CH);
      if (!found && en[ix]) begin
        r     = ix;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    ld        = !out_valid || out_ready;
    cand      = mode ? ptr : sel;
    chan_ok   = mode ? chan_en[ptr] : (int'(sel) < N_CH);
    in_ready  = '0;
    cand_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cand == SELW'(k)) begin
        cand_data = in_data[k*DW +: DW];
        if (rst_n && ld && chan_ok) in_ready[k] = 1'b1;
      end
    end
    xfer    = |(in_valid & in_ready);
    ptr_nxt = ptr;
    // Idle or masked channels are skipped rather than waited on.
    if (mode && ld && (xfer || !chan_en[ptr] || !in_valid[ptr]))
      ptr_nxt = next_en(ptr, chan_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
`ifdef CHAN_MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      ptr <= ptr_nxt;
      if (xfer) begin
        out_data  <= cand_data;
        out_ch    <= cand;
        out_valid <= 1'b1;
`ifdef CHAN_MUX_PARITY_EN
        out_par   <= ^cand_data;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb/tb_chan_mux_scan.sv - directed self-checking bench for chan_mux_scan
// Parity checks are compiled in only when CHAN_MUX_PARITY_EN is defined.
module tb_chan_mux_scan;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  chan_en;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef CHAN_MUX_PARITY_EN
  logic        out_par;
`endif

  int errors = 0;
  int checks = 0;

  chan_mux_scan #(.N_CH(4), .DW(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .chan_en(chan_en),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
`ifdef CHAN_MUX_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; in_data = 64'h4444_3333_2222_1111;
    mode = 1'b0; sel = 2'd2; chan_en = 4'hF; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
`ifdef CHAN_MUX_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL rst_out_par: got %b want 0", out_par); end
`endif
    in_valid = 4'h0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL rst_release_ready: got %b want 0100", in_ready); end
  endtask

  task automatic test_manual_latency();
    sel = 2'd1; in_data = 64'h0000_0000_A5A5_0000; in_valid = 4'b0010;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL man_ready: got %b want 0010", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL man_pre_valid: got %b want 0", out_valid); end
    tick();
    in_valid = 4'b0000;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL man_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 16'hA5A5) begin errors++; $display("FAIL man_data: got %h want a5a5", out_data); end
    checks++; if (out_ch !== 2'd1) begin errors++; $display("FAIL man_ch: got %0d want 1", out_ch); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL man_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    sel = 2'd0; in_data = 64'h0000_0000_0000_1234; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL stall_load: got %h want 1234", out_data); end
    out_ready = 1'b0; in_data = 64'h0000_0000_0000_FFFF;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i + 1);
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      checks++; if (out_data !== 16'h1234 || out_ch !== 2'd0 || out_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold[%0d]: got %h ch%0d v%b want 1234 ch0 v1", i, out_data, out_ch, out_valid); end
    end
    sel = 2'd0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready: got %b want 0001", in_ready); end
    tick();
    in_valid = 4'b0000;
    checks++; if (out_data !== 16'hFFFF || out_valid !== 1'b1) begin errors++; $display("FAIL stall_release_data: got %h v%b want ffff v1", out_data, out_valid); end
    tick();
  endtask

  task automatic test_auto_scan();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    mode = 1'b1; chan_en = 4'b1011; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 64'h1003_1002_1001_1000;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL scan_no_ch2[%0d]: got %b want 0", i, in_ready[2]); end
      tick();
      checks++; if (out_ch !== exp_seq[i] || out_data !== (16'h1000 + 16'(exp_seq[i])))
        begin errors++; $display("FAIL scan_seq[%0d]: got ch%0d %h want ch%0d", i, out_ch, out_data, exp_seq[i]); end
    end
    in_valid = 4'h0;
  endtask

  task automatic test_skip_idle();
    chan_en = 4'b1111; in_valid = 4'b0100; in_data = 64'h0000_CAFE_0000_0000;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++; if (out_valid !== (e % 4 == 3)) begin errors++; $display("FAIL skip_valid[%0d]: got %b want %b", e, out_valid, (e % 4 == 3)); end
      if (e % 4 == 3) begin
        checks++; if (out_ch !== 2'd2 || out_data !== 16'hCAFE) begin errors++; $display("FAIL skip_grant[%0d]: got ch%0d %h want ch2 cafe", e, out_ch, out_data); end
      end
    end
    // ptr is now 2; an empty mask must freeze it there.
    chan_en = 4'b0000; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL empty_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid[%0d]: got %b want 0", i, out_valid); end
    end
    chan_en = 4'b1111; in_valid = 4'h0;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL empty_ptr_frozen: got %b want 0100", in_ready); end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_data = 64'h7777_0000_0000_0000;
    tick();
    checks++; if (out_ch !== 2'd3 || out_data !== 16'h7777) begin errors++; $display("FAIL mode_manual: got ch%0d %h want ch3 7777", out_ch, out_data); end
    mode = 1'b1; in_valid = 4'h0;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL mode_resume_ptr: got %b want 0100", in_ready); end
    mode = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    sel = 2'd1; in_data = 64'h0000_0000_0007_0000; in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'h0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0007) begin errors++; $display("FAIL rms_load: got %h v%b want 0007 v1", out_data, out_valid); end
`ifdef CHAN_MUX_PARITY_EN
    checks++; if (out_par !== 1'b1) begin errors++; $display("FAIL par_0007: got %b want 1", out_par); end
`endif
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_async_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rms_async_data: got %h want 0000", out_data); end
    #1;
    rst_n = 1'b1;
    mode = 1'b1; chan_en = 4'hF; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rms_ptr_zero: got %b want 0001", in_ready); end
`ifdef CHAN_MUX_PARITY_EN
    mode = 1'b0; sel = 2'd2; in_data = 64'h0000_0003_0000_0000; in_valid = 4'b0100;
    tick();
    in_valid = 4'h0;
    checks++; if (out_par !== 1'b0 || out_data !== 16'h0003) begin errors++; $display("FAIL par_0003: got %b %h want 0 0003", out_par, out_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_manual_latency();
    test_stall();
    test_auto_scan();
    test_skip_idle();
    test_mode_switch();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
